// File: rtl/cdb_broadcaster_pkg.sv
// Shared widths and conventions for the result path into the reorder buffer.
package cdb_broadcaster_pkg;

  localparam int unsigned ROB_TAG_BITS  = 5;
  localparam int unsigned ARCH_REG_BITS = 5;
  localparam int unsigned CDB_DATA_BITS = 64;

  // All-ones tag marks "no ROB entry".
  localparam logic [ROB_TAG_BITS-1:0] NO_ROB_ENTRY = '1;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found scanning upward from ptr+1.
module rr_arbiter
  import cdb_broadcaster_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = idx_bits(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_grant_o
);

  logic [IW-1:0] cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    cand        = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(ptr_i) + k) % N);
      if (!any_grant_o && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
        any_grant_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// Collects FU results into one-entry holding registers and broadcasts one per cycle on the CDB.
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter  int unsigned NUM_FU    = 4,
  parameter  int unsigned TAG_BITS  = ROB_TAG_BITS,
  parameter  int unsigned REG_BITS  = ARCH_REG_BITS,
  parameter  int unsigned DATA_BITS = CDB_DATA_BITS,
  localparam int unsigned PW        = idx_bits(NUM_FU),
  localparam int unsigned OW        = $clog2(NUM_FU + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_FU-1:0]             fu_valid,
  input  logic [NUM_FU*TAG_BITS-1:0]    fu_tag,
  input  logic [NUM_FU*REG_BITS-1:0]    fu_reg,
  input  logic [NUM_FU*DATA_BITS-1:0]   fu_value,
  output logic [NUM_FU-1:0]             fu_ready,
  output logic                          cdb_valid,
  output logic [TAG_BITS-1:0]           cdb_tag,
  output logic [REG_BITS-1:0]           cdb_reg,
  output logic [DATA_BITS-1:0]          cdb_value,
  output logic [OW-1:0]                 hold_occupancy
);

  logic [NUM_FU-1:0]    hold_valid_q, hold_valid_d;
  logic [TAG_BITS-1:0]  hold_tag_q   [NUM_FU];
  logic [REG_BITS-1:0]  hold_reg_q   [NUM_FU];
  logic [DATA_BITS-1:0] hold_value_q [NUM_FU];
  logic [PW-1:0]        ptr_q;
  logic                 cdb_valid_q;
  logic [TAG_BITS-1:0]  cdb_tag_q;
  logic [REG_BITS-1:0]  cdb_reg_q;
  logic [DATA_BITS-1:0] cdb_value_q;
  logic [OW-1:0]        occ_q, occ_d;

  logic [NUM_FU-1:0]    req, grant, accept;
  logic [PW-1:0]        grant_idx;
  logic                 any_grant;

  assign req = flush ? '0 : hold_valid_q;

  rr_arbiter #(.N(NUM_FU)) u_arb (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  // A granted entry drains this edge, so its FU may refill it in the same cycle.
  assign fu_ready = flush ? '0 : (~hold_valid_q | grant);
  assign accept   = fu_valid & fu_ready;

  always_comb begin
    hold_valid_d = flush ? '0 : ((hold_valid_q & ~grant) | accept);
    occ_d        = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      occ_d = occ_d + OW'(hold_valid_d[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid_q <= '0;
      ptr_q        <= PW'(NUM_FU - 1);
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_reg_q    <= '0;
      cdb_value_q  <= '0;
      occ_q        <= '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        hold_tag_q[i]   <= TAG_BITS'(NO_ROB_ENTRY);
        hold_reg_q[i]   <= '0;
        hold_value_q[i] <= '0;
      end
    end else begin
      hold_valid_q <= hold_valid_d;
      occ_q        <= occ_d;
      if (any_grant) begin
        cdb_valid_q <= 1'b1;
        cdb_tag_q   <= hold_tag_q[grant_idx];
        cdb_reg_q   <= hold_reg_q[grant_idx];
        cdb_value_q <= hold_value_q[grant_idx];
        ptr_q       <= grant_idx;
      end else begin
        cdb_valid_q <= 1'b0;
      end
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (accept[i]) begin
          hold_tag_q[i]   <= fu_tag[i*TAG_BITS +: TAG_BITS];
          hold_reg_q[i]   <= fu_reg[i*REG_BITS +: REG_BITS];
          hold_value_q[i] <= fu_value[i*DATA_BITS +: DATA_BITS];
        end
      end
    end
  end

  assign cdb_valid      = cdb_valid_q;
  assign cdb_tag        = cdb_tag_q;
  assign cdb_reg        = cdb_reg_q;
  assign cdb_value      = cdb_value_q;
  assign hold_occupancy = occ_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: vector table, directed corner cases, random scoreboard run.
module tb_cdb_broadcaster;

  localparam int NF = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         flush;
  logic [3:0]   fu_valid;
  logic [19:0]  fu_tag;
  logic [19:0]  fu_reg;
  logic [255:0] fu_value;
  logic [3:0]   fu_ready;
  logic         cdb_valid;
  logic [4:0]   cdb_tag;
  logic [4:0]   cdb_reg;
  logic [63:0]  cdb_value;
  logic [2:0]   hold_occupancy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  cdb_broadcaster #(.NUM_FU(4), .TAG_BITS(5), .REG_BITS(5), .DATA_BITS(64)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .fu_valid       (fu_valid),
    .fu_tag         (fu_tag),
    .fu_reg         (fu_reg),
    .fu_value       (fu_value),
    .fu_ready       (fu_ready),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_reg        (cdb_reg),
    .cdb_value      (cdb_value),
    .hold_occupancy (hold_occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  v;
    logic        fl;
    logic [19:0] tags;
    logic [3:0]  ready;
    logic        cv;
    logic [4:0]  tag;
    logic [2:0]  occ;
  } vec_t;

  typedef struct {
    logic        cv;
    logic [4:0]  tag;
    logic [4:0]  rg;
    logic [63:0] val;
    logic [2:0]  occ;
  } exp_t;

  vec_t tbl [23];
  exp_t sbq [$];

  function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [4:0] reg_of(input logic [4:0] t);
    return ~t;
  endfunction

  function automatic logic [63:0] val_of(input logic [4:0] t);
    return {32'hCAFE_0000, 27'd0, t};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_tbl(input logic [3:0] v, input logic fl, input logic [19:0] tags);
    fu_valid = v;
    flush    = fl;
    fu_tag   = tags;
    for (int i = 0; i < NF; i++) begin
      fu_reg[i*5 +: 5]    = reg_of(tags[i*5 +: 5]);
      fu_value[i*64 +: 64] = val_of(tags[i*5 +: 5]);
    end
  endtask

  task automatic sb_check(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got cdb_valid %0b expected a queued entry", name, cdb_valid);
    end else begin
      e = sbq.pop_front();
      check({name, " cdb_valid"}, 64'(cdb_valid), 64'(e.cv));
      if (e.cv) begin
        check({name, " cdb_tag"}, 64'(cdb_tag), 64'(e.tag));
        check({name, " cdb_reg"}, 64'(cdb_reg), 64'(e.rg));
        check({name, " cdb_value"}, cdb_value, e.val);
      end
      check({name, " occupancy"}, 64'(hold_occupancy), 64'(e.occ));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_tbl(4'b0000, 1'b0, '0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    sbq.delete();
  endtask

  // Independent reference: picks the requester at minimum circular distance after ptr.
  task automatic run_random(input int cycles);
    bit          m_hv [NF];
    logic [4:0]  m_tag [NF];
    logic [4:0]  m_reg [NF];
    logic [63:0] m_val [NF];
    int          m_ptr;
    bit          o_v [NF];
    logic [4:0]  o_tag [NF];
    logic [4:0]  o_reg [NF];
    logic [63:0] o_val [NF];
    logic [3:0]  exp_ready;
    bit          fl;
    int          g, best, d, cnt;
    exp_t        e;
    m_ptr = NF - 1;
    for (int i = 0; i < NF; i++) begin
      m_hv[i] = 1'b0;
      o_v[i]  = 1'b0;
    end
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NF; i++) begin
        if (!o_v[i] && ($urandom_range(0, 1) == 1)) begin
          o_v[i]   = 1'b1;
          o_tag[i] = 5'($urandom);
          o_reg[i] = 5'($urandom);
          o_val[i] = {$urandom, $urandom};
        end
        fu_valid[i]          = o_v[i];
        fu_tag[i*5 +: 5]     = o_tag[i];
        fu_reg[i*5 +: 5]     = o_reg[i];
        fu_value[i*64 +: 64] = o_val[i];
      end
      fl    = ($urandom_range(0, 15) == 0);
      flush = fl;
      g = -1;
      best = NF;
      if (!fl) begin
        for (int i = 0; i < NF; i++) begin
          if (m_hv[i]) begin
            d = (i - m_ptr - 1 + 2 * NF) % NF;
            if (d < best) begin
              best = d;
              g = i;
            end
          end
        end
      end
      for (int i = 0; i < NF; i++) exp_ready[i] = !fl && (!m_hv[i] || g == i);
      #1;
      check($sformatf("rnd%0d ready", c), 64'(fu_ready), 64'(exp_ready));
      e = '{1'b0, 5'd0, 5'd0, 64'd0, 3'd0};
      if (fl) begin
        for (int i = 0; i < NF; i++) begin
          m_hv[i] = 1'b0;
          o_v[i]  = 1'b0;
        end
      end else begin
        if (g >= 0) begin
          e.cv  = 1'b1;
          e.tag = m_tag[g];
          e.rg  = m_reg[g];
          e.val = m_val[g];
          m_ptr = g;
          m_hv[g] = 1'b0;
        end
        for (int i = 0; i < NF; i++) begin
          if (o_v[i] && exp_ready[i]) begin
            m_hv[i]  = 1'b1;
            m_tag[i] = o_tag[i];
            m_reg[i] = o_reg[i];
            m_val[i] = o_val[i];
            o_v[i]   = 1'b0;
          end
        end
      end
      cnt = 0;
      for (int i = 0; i < NF; i++) cnt += int'(m_hv[i]);
      e.occ = 3'(cnt);
      sbq.push_back(e);
      tick();
      sb_check($sformatf("rnd%0d", c));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //            v        fl    tags                ready    cv    tag    occ
    tbl[0]  = '{4'b1111, 1'b0, pk(1, 2, 3, 4),    4'b1111, 1'b0, 5'd0,  3'd4};
    tbl[1]  = '{4'b1111, 1'b0, pk(1, 2, 3, 4),    4'b0001, 1'b1, 5'd1,  3'd4};
    tbl[2]  = '{4'b1111, 1'b0, pk(1, 2, 3, 4),    4'b0010, 1'b1, 5'd2,  3'd4};
    tbl[3]  = '{4'b1111, 1'b0, pk(1, 2, 3, 4),    4'b0100, 1'b1, 5'd3,  3'd4};
    tbl[4]  = '{4'b1111, 1'b0, pk(1, 2, 3, 4),    4'b1000, 1'b1, 5'd4,  3'd4};
    tbl[5]  = '{4'b1111, 1'b0, pk(1, 2, 3, 4),    4'b0001, 1'b1, 5'd1,  3'd4};
    tbl[6]  = '{4'b0010, 1'b0, pk(0, 9, 0, 0),    4'b0010, 1'b1, 5'd2,  3'd4};
    tbl[7]  = '{4'b0000, 1'b0, pk(0, 0, 0, 0),    4'b0100, 1'b1, 5'd3,  3'd3};
    tbl[8]  = '{4'b0000, 1'b0, pk(0, 0, 0, 0),    4'b1100, 1'b1, 5'd4,  3'd2};
    tbl[9]  = '{4'b0000, 1'b0, pk(0, 0, 0, 0),    4'b1101, 1'b1, 5'd1,  3'd1};
    tbl[10] = '{4'b0000, 1'b0, pk(0, 0, 0, 0),    4'b1111, 1'b1, 5'd9,  3'd0};
    tbl[11] = '{4'b0000, 1'b0, pk(0, 0, 0, 0),    4'b1111, 1'b0, 5'd0,  3'd0};
    tbl[12] = '{4'b0010, 1'b0, pk(0, 10, 0, 0),   4'b1111, 1'b0, 5'd0,  3'd1};
    tbl[13] = '{4'b0010, 1'b0, pk(0, 11, 0, 0),   4'b1111, 1'b1, 5'd10, 3'd1};
    tbl[14] = '{4'b0010, 1'b0, pk(0, 12, 0, 0),   4'b1111, 1'b1, 5'd11, 3'd1};
    tbl[15] = '{4'b0000, 1'b0, pk(0, 0, 0, 0),    4'b1111, 1'b1, 5'd12, 3'd0};
    tbl[16] = '{4'b0000, 1'b0, pk(0, 0, 0, 0),    4'b1111, 1'b0, 5'd0,  3'd0};
    tbl[17] = '{4'b0111, 1'b0, pk(5, 6, 7, 0),    4'b1111, 1'b0, 5'd0,  3'd3};
    tbl[18] = '{4'b1000, 1'b1, pk(0, 0, 0, 13),   4'b0000, 1'b0, 5'd0,  3'd0};
    tbl[19] = '{4'b0000, 1'b0, pk(0, 0, 0, 0),    4'b1111, 1'b0, 5'd0,  3'd0};
    tbl[20] = '{4'b1000, 1'b0, pk(0, 0, 0, 8),    4'b1111, 1'b0, 5'd0,  3'd1};
    tbl[21] = '{4'b0000, 1'b0, pk(0, 0, 0, 0),    4'b1111, 1'b1, 5'd8,  3'd0};
    tbl[22] = '{4'b0000, 1'b0, pk(0, 0, 0, 0),    4'b1111, 1'b0, 5'd0,  3'd0};

    // Reset values and a single result from FU2.
    do_reset();
    check("reset cdb_valid", 64'(cdb_valid), 64'd0);
    check("reset cdb_tag", 64'(cdb_tag), 64'd0);
    check("reset cdb_reg", 64'(cdb_reg), 64'd0);
    check("reset cdb_value", cdb_value, 64'd0);
    check("reset occupancy", 64'(hold_occupancy), 64'd0);
    check("reset fu_ready", 64'(fu_ready), 64'hF);
    fu_valid = 4'b0100;
    fu_tag[10 +: 5]     = 5'd7;
    fu_reg[10 +: 5]     = 5'd3;
    fu_value[128 +: 64] = 64'hDEAD;
    #1;
    check("single ready2", 64'(fu_ready[2]), 64'd1);
    tick();
    check("single c1 cdb_valid", 64'(cdb_valid), 64'd0);
    fu_valid = 4'b0000;
    tick();
    check("single c2 cdb_valid", 64'(cdb_valid), 64'd1);
    check("single c2 cdb_tag", 64'(cdb_tag), 64'd7);
    check("single c2 cdb_reg", 64'(cdb_reg), 64'd3);
    check("single c2 cdb_value", cdb_value, 64'hDEAD);
    tick();
    check("single c3 cdb_valid", 64'(cdb_valid), 64'd0);

    // Fairness, back-pressure, streaming refill and flush through the table.
    do_reset();
    for (int k = 0; k < 23; k++) begin
      drive_tbl(tbl[k].v, tbl[k].fl, tbl[k].tags);
      #1;
      check($sformatf("tbl%0d ready", k), 64'(fu_ready), 64'(tbl[k].ready));
      sbq.push_back('{tbl[k].cv, tbl[k].tag, reg_of(tbl[k].tag), val_of(tbl[k].tag), tbl[k].occ});
      tick();
      sb_check($sformatf("tbl%0d", k));
    end

    // Asynchronous reset between edges while a broadcast is live.
    drive_tbl(4'b1111, 1'b0, pk(1, 2, 3, 4));
    tick();
    tick();
    check("arst pre cdb_valid", 64'(cdb_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst cdb_valid", 64'(cdb_valid), 64'd0);
    check("arst occupancy", 64'(hold_occupancy), 64'd0);
    #1;
    reset = 1'b0;
    tick();
    check("arst accept cdb_valid", 64'(cdb_valid), 64'd0);
    tick();
    check("arst first cdb_valid", 64'(cdb_valid), 64'd1);
    check("arst first cdb_tag", 64'(cdb_tag), 64'd1);

    // Random traffic against the reference model.
    do_reset();
    run_random(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
